// File: rtl/conv_pkg.sv
// Shared definitions for the streaming KxK convolution frame sequencer.
// Holds geometry defaults, FSM state codes and the result-count helper.
// No logic of its own; imported by the controller and its output slot.
package conv_pkg;

  // Default geometry and widths
  localparam int DEF_N  = 5;
  localparam int DEF_M  = 5;
  localparam int DEF_K  = 3;
  localparam int DEF_PW = 8;
  localparam int DEF_OW = 16;

  // Frame sequencer states
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  // Number of fully-inside windows in an n x m image for a k x k kernel
  function automatic int conv_total(input int n, input int m, input int k);
    return (m - k + 1) * (n - k + 1);
  endfunction

  // Counter width for a range of v values, never narrower than one bit
  function automatic int cnt_w(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/conv_stream_ctrl_out_slot.sv
// Single-entry result holding register between the datapath and the sink.
// Latency: pending result appears on vld_o/dat_o one cycle after load.
// Backpressure: loads only when empty or draining; holds data while rdy_i is low.
module out_slot
  import conv_pkg::*;
#(
  parameter int OW = DEF_OW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pend_i,
  input  logic [OW-1:0] sum_i,
  input  logic          rdy_i,
  output logic          vld_o,
  output logic [OW-1:0] dat_o,
  output logic          load_o
);

  logic          vld_q;
  logic [OW-1:0] dat_q;

  // A pending result may enter when the slot is empty or being emptied now
  assign load_o = pend_i && (!vld_q || rdy_i);
  assign vld_o  = vld_q;
  assign dat_o  = dat_q;

  // Load wins over unload so a simultaneous load/unload keeps the slot full
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else if (load_o) begin
      vld_q <= 1'b1;
      dat_q <= sum_i;
    end else if (vld_q && rdy_i) begin
      vld_q <= 1'b0;
    end
  end

endmodule

// File: rtl/conv_stream_ctrl.sv
// Frame sequencer: paces a raster pixel stream into the conv datapath and qualifies results.
// Latency: a qualifying pixel accepted in cycle t yields out_valid in cycle t+2.
// Backpressure: in_ready drops while a qualified result waits for a full, stalled output slot.
module conv_stream_ctrl
  import conv_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int M  = DEF_M,
  parameter int K  = DEF_K,
  parameter int PW = DEF_PW,
  parameter int OW = DEF_OW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [PW-1:0] in_data,
  output logic          in_ready,
  output logic          pipe_en,
  output logic          pipe_clr,
  output logic [PW-1:0] pipe_pxl,
  input  logic [OW-1:0] pipe_sum,
  output logic          out_valid,
  output logic [OW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  localparam int TOTAL = conv_total(N, M, K);
  localparam int CW    = cnt_w(N);
  localparam int RW    = cnt_w(M);
  localparam int TW    = cnt_w(TOTAL + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(N - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);
  localparam logic [CW-1:0] COL_QUAL = CW'(K - 1);
  localparam logic [RW-1:0] ROW_QUAL = RW'(K - 1);
  localparam logic [TW-1:0] RES_LAST = TW'(TOTAL - 1);

  if (K > N || K > M) begin : g_bad_geometry
    $error("conv_stream_ctrl: kernel size K exceeds image dimensions");
  end

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [TW-1:0] out_cnt_q, out_cnt_d;
  logic          pend_q, pend_d;

  logic acc;
  logic qual;
  logic last_pix;
  logic out_fire;
  logic frame_end;
  logic slot_load;

  // Handshake, datapath enable and status decode
  always_comb begin
    in_ready  = (state_q == RUN) && !(pend_q && out_valid && !out_ready);
    acc       = in_valid && in_ready;
    pipe_en   = acc;
    pipe_pxl  = in_data;
    pipe_clr  = reset || ((state_q == IDLE) && start);
    qual      = (row_q >= ROW_QUAL) && (col_q >= COL_QUAL);
    last_pix  = (row_q == ROW_LAST) && (col_q == COL_LAST);
    out_fire  = out_valid && out_ready;
    frame_end = (state_q == FLUSH) && out_fire && (out_cnt_q == RES_LAST);
    done      = frame_end;
    busy      = (state_q == RUN) || (state_q == FLUSH);
  end

  // Next state: position counters, window qualification, result count, FSM
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    out_cnt_d = out_cnt_q;
    pend_d    = pend_q;

    // acc while pending implies the slot loads this cycle, so the new flag replaces the old
    if (acc) begin
      pend_d = qual;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end else if (slot_load) begin
      pend_d = 1'b0;
    end

    if (out_fire) begin
      out_cnt_d = out_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          row_d     = '0;
          col_d     = '0;
          out_cnt_d = '0;
          pend_d    = 1'b0;
        end
      end
      RUN: begin
        if (acc && last_pix) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (frame_end) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      out_cnt_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      out_cnt_q <= out_cnt_d;
      pend_q    <= pend_d;
    end
  end

  out_slot #(
    .OW(OW)
  ) u_out_slot (
    .clk    (clk),
    .reset  (reset),
    .pend_i (pend_q),
    .sum_i  (pipe_sum),
    .rdy_i  (out_ready),
    .vld_o  (out_valid),
    .dat_o  (out_data),
    .load_o (slot_load)
  );

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Bench for conv_stream_ctrl: datapath stand-in plus whole-frame expected results.
// Inputs change at the falling edge; outputs are read 1 time unit later.
// Every frame is bounded by a cycle budget.
module tb_conv_stream_ctrl;
  import conv_pkg::*;

  localparam int N     = 5;
  localparam int M     = 5;
  localparam int K     = 3;
  localparam int PW    = 8;
  localparam int OW    = 16;
  localparam int TOTAL = (M - K + 1) * (N - K + 1);
  localparam int NPIX  = N * M;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [PW-1:0] in_data;
  logic          in_ready;
  logic          pipe_en;
  logic          pipe_clr;
  logic [PW-1:0] pipe_pxl;
  logic [OW-1:0] pipe_sum;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_ready;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  conv_stream_ctrl #(.N(N), .M(M), .K(K), .PW(PW), .OW(OW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .pipe_en(pipe_en), .pipe_clr(pipe_clr), .pipe_pxl(pipe_pxl),
    .pipe_sum(pipe_sum), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  // Kernel [1 2 1; 0 0 0; 1 2 1] applied to the window whose bottom-right pixel is (r,c)
  function automatic int win_sum(input int img[NPIX], input int r, input int c);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (i != 1) s += ((j == 1) ? 2 : 1) * img[(r - 2 + i) * N + (c - 2 + j)];
    return s;
  endfunction

  // Datapath output after pixel number k arrives; partial windows give a distinct junk value
  function automatic int dp_next(input int img[NPIX], input int k, input int px);
    int t[NPIX];
    t = img;
    t[k] = px;
    if ((k / N) >= 2 && (k % N) >= 2) return win_sum(t, k / N, k % N);
    return px * 3 + 7;
  endfunction

  int dp_img[NPIX];
  int dp_k;

  // Datapath stand-in: registered result advancing only on pipe_en, cleared by pipe_clr
  always @(posedge clk) begin
    if (pipe_clr) begin
      dp_k     <= 0;
      pipe_sum <= '0;
    end else if (pipe_en && dp_k < NPIX) begin
      dp_img[dp_k] <= int'(pipe_pxl);
      dp_k         <= dp_k + 1;
      pipe_sum     <= OW'(dp_next(dp_img, dp_k, int'(pipe_pxl)));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One frame: start pulse, pixel feed with optional gaps/backpressure/stray start/reset
  task automatic run_frame(input string nm, input bit seq_pix, input int gap, input int bp_len,
                           input int mid_start_at, input int reset_after, input bit start_on_done);
    int pix[NPIX];
    int exp_q[$];
    int idx = 0, ocount = 0, cyc = 0, t13 = -1, tfirst = -1, bp_left = 0;
    bit stalled = 0, saw_valid = 0, fin = 0, do_reset = 0;

    for (int i = 0; i < NPIX; i++) pix[i] = seq_pix ? i + 1 : int'($urandom_range(0, 255));
    for (int r = K - 1; r < M; r++)
      for (int c = K - 1; c < N; c++) exp_q.push_back(win_sum(pix, r, c));

    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check({nm, "/idle_busy"}, busy, 0);
    check({nm, "/clr_on_start"}, pipe_clr, 1);
    @(negedge clk);
    start = 1'b0;
    #1;
    check({nm, "/run_busy"}, busy, 1);
    check({nm, "/clr_one_cycle"}, pipe_clr, 0);

    while (!fin && cyc < 600) begin
      @(negedge clk);
      start    = (mid_start_at >= 0) && (idx == mid_start_at);
      in_valid = (idx < NPIX) && (cyc % gap == 0);
      in_data  = in_valid ? PW'(pix[idx]) : PW'($urandom_range(0, 255));
      if (bp_left > 0) begin
        out_ready = 1'b0;
        bp_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (start_on_done && out_valid && out_ready && ocount == TOTAL - 1) start = 1'b1;
      #1;
      if (start) check({nm, "/start_ignored_clr"}, pipe_clr, 0);
      check({nm, "/pipe_en"}, pipe_en, in_valid && in_ready);
      if (pipe_en) check({nm, "/pipe_pxl"}, pipe_pxl, in_data);
      if (idx >= NPIX) check({nm, "/in_ready_after_last"}, in_ready, 0);
      if (in_valid && !in_ready) stalled = 1;
      if (out_valid && out_ready) begin
        if (ocount < TOTAL) check({nm, "/out_data"}, out_data, exp_q[ocount]);
        else check({nm, "/extra_result"}, ocount, TOTAL - 1);
        check({nm, "/done_on_fire"}, done, ocount == TOTAL - 1);
        ocount++;
        if (ocount >= TOTAL) fin = 1;
      end else begin
        check({nm, "/done_idle"}, done, 0);
      end
      if (out_valid && !saw_valid) begin
        saw_valid = 1;
        tfirst    = cyc;
        bp_left   = bp_len;
      end
      if (in_valid && in_ready) begin
        if (idx == 12) t13 = cyc;
        idx++;
      end
      if (reset_after > 0 && idx == reset_after) begin
        fin      = 1;
        do_reset = 1;
      end
      cyc++;
    end

    if (do_reset) begin
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
      #1;
      check({nm, "/clr_in_reset"}, pipe_clr, 1);
      check({nm, "/no_done_in_reset"}, done, 0);
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b1;
      #1;
      check({nm, "/rst_out_valid"}, out_valid, 0);
      check({nm, "/rst_busy"}, busy, 0);
      check({nm, "/rst_done"}, done, 0);
      check({nm, "/idle_in_ready"}, in_ready, 0);
      in_valid = 1'b0;
    end else begin
      check({nm, "/frame_finished"}, fin, 1);
      check({nm, "/result_count"}, ocount, TOTAL);
      check({nm, "/pixel_count"}, idx, NPIX);
      if (gap == 1 && bp_len == 0) check({nm, "/first_latency"}, tfirst - t13, 2);
      if (gap == 1 && bp_len > 0) check({nm, "/stall_seen"}, stalled, 1);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset/out_valid", out_valid, 0);
    check("reset/out_data", out_data, 0);
    check("reset/in_ready", in_ready, 0);
    check("reset/pipe_en", pipe_en, 0);
    check("reset/busy", busy, 0);
    check("reset/done", done, 0);
    check("reset/pipe_clr", pipe_clr, 1);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b1;
    #1;
    check("idle/pipe_clr", pipe_clr, 0);
    check("idle/in_ready", in_ready, 0);
    in_valid = 1'b0;

    run_frame("s1_plain",      1, 1, 0, -1,  0, 0);
    run_frame("s2_backpress",  1, 1, 5, -1,  0, 0);
    run_frame("s3_sparse",     1, 3, 0, -1,  0, 0);
    run_frame("s4_mid_start",  0, 1, 0,  6,  0, 0);
    run_frame("s5_reset",      0, 1, 0, -1, 15, 0);
    run_frame("s5_after_rst",  0, 1, 0, -1,  0, 1);
    run_frame("s6_back2back",  0, 2, 3, -1,  0, 0);

    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    #1;
    check("end/busy", busy, 0);
    check("end/out_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
